fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   IF stage directly upstream of instructionMemory. Owns the PC and drives the
//   memory read address, then assembles 1- or 2-word instructions into the IF/ID
//   pipeline register. Also applies stall, flush and branch redirect from later stages.
// PARAMETERS
//   PC_W      32     PC / memory address width (word-indexed)
//   INSTR_W   16     memory word width
//   RESET_PC  32'h0  PC value loaded on reset
// PORTS
//   clk            in   1        single clock, all state on posedge
//   rst            in   1        asynchronous, active-low reset
//   imem_addr      out  PC_W     read address to instruction memory (= pc, combinational)
//   imem_data      in   INSTR_W  word at imem_addr; memory samples on negedge, stable by next posedge
//   stall          in   1        hold PC, FSM and IF/ID outputs
//   flush          in   1        kill IF/ID contents and any partial 2-word fetch
//   branch_taken   in   1        redirect request
//   branch_target  in   PC_W     redirect PC
//   if_valid       out  1        IF/ID holds a real instruction
//   if_instr       out  32       {opcode word, immediate word}; immediate = 16'h0 for 1-word ops
//   if_pc          out  PC_W     address of the opcode word of if_instr
//   if_pc_next     out  PC_W     address following the full instruction
// BEHAVIOUR
//   Reset (rst=0, async): pc=RESET_PC, state=S_OP, op_hold=0, if_valid=0,
//     if_instr=0, if_pc=0, if_pc_next=0. First fetch uses RESET_PC on the first posedge after release.
//   Latency: word at pc is captured on the posedge that ends the cycle pc was driven.
//     A 1-word instruction appears at the IF/ID outputs 1 cycle after its fetch cycle.
//     A 2-word instruction appears 2 cycles after its fetch cycle.
//   Encoding: imem_data[15]==1 marks a 2-word op; the next word is a 16-bit immediate.
//   FSM, evaluated each posedge when not stalled and not redirected:
//     S_OP,  bit15=0: if_instr<={word,16'h0}, if_valid<=1, if_pc<=pc, if_pc_next<=pc+1,
//                     pc<=pc+1, stay S_OP.
//     S_OP,  bit15=1: op_hold<=word, op_pc<=pc, if_valid<=0, pc<=pc+1, -> S_IMM.
//     S_IMM: if_instr<={op_hold,word}, if_valid<=1, if_pc<=op_pc, if_pc_next<=pc+1,
//            pc<=pc+1, -> S_OP. Bit15 of the immediate word is not decoded.
//   Priority, highest first: branch_taken > flush > stall > normal.
//     branch_taken: pc<=branch_target, state<=S_OP, if_valid<=0. Applies even when stall=1.
//     flush (no branch): if_valid<=0, state<=S_OP, pc<=op_pc if state was S_IMM, else pc holds.
//       In either case the partially fetched instruction is refetched.
//     stall: all registers hold, including op_hold in S_IMM. imem_addr stays = pc.
//   Arithmetic: pc+1 is modulo 2^PC_W; pc=32'hFFFF_FFFF wraps to 0 with no flag.
//     A 2-word op at FFFF_FFFF takes its immediate from address 0.
//   Reset mid-operation: an in-flight 2-word fetch is dropped; no output glitches beyond async clear.
//   if_instr/if_pc/if_pc_next are don't-care when if_valid=0 but must hold their last value (no X).
// STRUCTURE
//   fetch_pkg: typedef enum {S_OP,S_IMM} fetch_state_t; LONG_OP_BIT=15; NOP_WORD=16'h0000.
//   One sub-module: fetch_pc_reg. It holds the PC register, the next-PC mux
//     (target / op_pc / pc / pc+1) and async reset.
//     The FSM and IF/ID register stay in fetch_unit.
// TESTING
//   1 Reset: rst low mid-run -> pc=0, if_valid=0 immediately. Release, mem[0]=16'h1234
//     -> if_instr=32'h1234_0000, if_pc=0, if_pc_next=1.
//   2 Two-word: mem[4]=16'h8001, mem[5]=16'hBEEF -> one bubble, then if_instr=32'h8001_BEEF,
//     if_pc=4, if_pc_next=6.
//   3 Stall in S_IMM: stall=1 for 3 cycles after opcode 16'h8001 fetched -> pc held at 5.
//     Release -> if_instr=32'h8001_BEEF still correct.
//   4 Branch with stall=1, target=32'h40 -> next cycle pc=32'h40, if_valid=0.
//     Following cycle if_pc=32'h40.
//   5 Flush in S_IMM (opcode at 8) -> pc returns to 8, state S_OP, if_valid=0,
//     then the 2-word op at 8 re-emerges.
//   6 Wrap: branch to 32'hFFFF_FFFF with 1-word op -> if_pc_next=0, next fetch address 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Covers the fetch FSM states, the PC mux selects and the 2-word opcode decode.
package fetch_pkg;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_TGT  = 2'd2,
    PC_OPPC = 2'd3
  } pc_sel_t;

  localparam int          LONG_OP_BIT = 15;
  localparam logic [15:0] NOP_WORD    = 16'h0000;

  function automatic logic is_long_op(input logic [15:0] word);
    return word[LONG_OP_BIT];
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC mux (target / op_pc / hold / pc+1).
// pc_inc wraps modulo 2^PC_W with no carry out.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_t         sel,
  input  logic [PC_W-1:0] target,
  input  logic [PC_W-1:0] op_pc,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_inc
);

  assign pc_inc = pc + PC_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else begin
      case (sel)
        PC_INC:  pc <= pc_inc;
        PC_TGT:  pc <= target;
        PC_OPPC: pc <= op_pc;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: drives the instruction memory address from the PC and assembles
// 1- or 2-word instructions into the IF/ID register, honouring branch/flush/stall.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_data,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 branch_taken,
  input  logic [PC_W-1:0]      branch_target,
  output logic                 if_valid,
  output logic [2*INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]      if_pc,
  output logic [PC_W-1:0]      if_pc_next
);

  fetch_state_t         state;
  logic [INSTR_W-1:0]   op_hold;
  logic [PC_W-1:0]      op_pc;
  logic [PC_W-1:0]      pc;
  logic [PC_W-1:0]      pc_inc;
  pc_sel_t              pc_sel;

  assign imem_addr = pc;

  // A flush mid 2-word fetch rewinds to the opcode so the whole op is refetched.
  always_comb begin
    pc_sel = PC_INC;
    if (branch_taken)
      pc_sel = PC_TGT;
    else if (flush)
      pc_sel = (state == S_IMM) ? PC_OPPC : PC_HOLD;
    else if (stall)
      pc_sel = PC_HOLD;
  end

  fetch_pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .sel    (pc_sel),
    .target (branch_target),
    .op_pc  (op_pc),
    .pc     (pc),
    .pc_inc (pc_inc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_OP;
      op_hold    <= '0;
      op_pc      <= '0;
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      if_pc_next <= '0;
    end else if (branch_taken || flush) begin
      state    <= S_OP;
      if_valid <= 1'b0;
    end else if (!stall) begin
      case (state)
        S_OP: begin
          if (is_long_op(16'(imem_data))) begin
            op_hold  <= imem_data;
            op_pc    <= pc;
            if_valid <= 1'b0;
            state    <= S_IMM;
          end else begin
            if_instr   <= {imem_data, INSTR_W'(NOP_WORD)};
            if_valid   <= 1'b1;
            if_pc      <= pc;
            if_pc_next <= pc_inc;
          end
        end
        S_IMM: begin
          // Immediate word is taken verbatim; its top bit is not an opcode flag.
          if_instr   <= {op_hold, imem_data};
          if_valid   <= 1'b1;
          if_pc      <= op_pc;
          if_pc_next <= pc_inc;
          state      <= S_OP;
        end
        default: state <= S_OP;
      endcase
    end
  end

endmodule
